// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: channel FSM encoding and counter sizing.
package debounce_pkg;

  // Per-channel debounce state; out is high in HELD and DISARMING.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    DISARMING = 2'd3
  } db_state_e;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce FSM, edge pulses and long-press timer.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES   = 20,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic pressed,
  output logic released,
  output logic long_press
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam int unsigned HW = cnt_width(HOLD_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   stable_hit;
  logic                   out_d;
  logic                   long_d;

  assign s          = sync_q[SYNC_STAGES-1];
  assign stable_hit = (32'(cnt_q) == (STABLE_CYCLES - 32'd1));

  // Input synchroniser chain; the last stage is the sample the FSM sees.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], in};
  end

  // Next state: count consecutive disagreeing samples, accept the new level on the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          if (stable_hit) state_d = HELD;
          else begin
            state_d = ARMING;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      ARMING: begin
        if (!s)             state_d = IDLE;
        else if (stable_hit) state_d = HELD;
        else                cnt_d   = cnt_q + CW'(1);
      end
      HELD: begin
        if (!s) begin
          if (stable_hit) state_d = IDLE;
          else begin
            state_d = DISARMING;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      DISARMING: begin
        if (s)              state_d = HELD;
        else if (stable_hit) state_d = IDLE;
        else                cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold timer: runs only while out stays high, saturates, fires once on reaching the limit.
  always_comb begin
    out_d  = (state_d == HELD) || (state_d == DISARMING);
    hold_d = hold_q;
    long_d = 1'b0;
    if (!(out_q_hi() && out_d)) begin
      hold_d = '0;
    end else if (32'(hold_q) < HOLD_CYCLES) begin
      hold_d = hold_q + HW'(1);
      long_d = ((32'(hold_q) + 32'd1) == HOLD_CYCLES);
    end
  end

  function automatic logic out_q_hi();
    return out;
  endfunction

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      out        <= 1'b0;
      pressed    <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      out        <= out_d;
      pressed    <= out_d & ~out;
      released   <= ~out_d & out;
      long_press <= long_d;
    end
  end

endmodule

// File: rtl/multi_button_debouncer.sv
// Bank of independent debounced button channels.
module multi_button_debouncer #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES   = 20,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] released,
  output logic [N_CH-1:0] long_press
);

  // One channel instance per button.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .in        (in[i]),
      .out       (out[i]),
      .pressed   (pressed[i]),
      .released  (released[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer with N_CH=4, STABLE=8, HOLD=20, SYNC=2.
module tb_multi_button_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [3:0] dout, pressed, released, long_press;

  int checks = 0;
  int passes = 0;

  // Per-channel event monitor, indexed by cycle since the last clear_mon.
  int cyc;
  int p_cnt [4], p_at [4];
  int r_cnt [4], r_at [4];
  int l_cnt [4], l_at [4];
  int o_cnt [4], o_at [4];

  multi_button_debouncer #(
    .N_CH(4), .STABLE_CYCLES(8), .HOLD_CYCLES(20), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .in(din), .out(dout),
    .pressed(pressed), .released(released), .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic clear_mon();
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      p_cnt[i] = 0; p_at[i] = -1;
      r_cnt[i] = 0; r_at[i] = -1;
      l_cnt[i] = 0; l_at[i] = -1;
      o_cnt[i] = 0; o_at[i] = -1;
    end
  endtask

  // Advance one clock, then record what each channel shows in the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (pressed[i])    begin p_cnt[i]++; if (p_at[i] < 0) p_at[i] = cyc; end
      if (released[i])   begin r_cnt[i]++; if (r_at[i] < 0) r_at[i] = cyc; end
      if (long_press[i]) begin l_cnt[i]++; if (l_at[i] < 0) l_at[i] = cyc; end
      if (dout[i])       begin o_cnt[i]++; if (o_at[i] < 0) o_at[i] = cyc; end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic settle();
    din = 4'h0;
    steps(25);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 4'h0;
    steps(2);
    checks++; if (dout !== 4'h0) $display("FAIL reset_out: got %h expected 0", dout); else passes++;
    checks++; if (pressed !== 4'h0) $display("FAIL reset_pressed: got %h expected 0", pressed); else passes++;
    checks++; if (released !== 4'h0) $display("FAIL reset_released: got %h expected 0", released); else passes++;
    checks++; if (long_press !== 4'h0) $display("FAIL reset_long: got %h expected 0", long_press); else passes++;
    rst = 1'b0;
    steps(3);
  endtask

  task automatic test_clean_press();
    clear_mon();
    din[0] = 1'b1;
    steps(9);
    checks++; if (dout[0] !== 1'b0) $display("FAIL clean_out_c9: got %b expected 0", dout[0]); else passes++;
    steps(11);
    checks++; if (o_at[0] != 10) $display("FAIL clean_out_rise: got %0d expected 10", o_at[0]); else passes++;
    checks++; if (p_at[0] != 10) $display("FAIL clean_pressed_at: got %0d expected 10", p_at[0]); else passes++;
    checks++; if (p_cnt[0] != 1) $display("FAIL clean_pressed_cnt: got %0d expected 1", p_cnt[0]); else passes++;
    checks++; if (p_cnt[3] != 0) $display("FAIL clean_other_ch: got %0d expected 0", p_cnt[3]); else passes++;
    clear_mon();
    din[0] = 1'b0;
    steps(20);
    checks++; if (r_at[0] != 10) $display("FAIL clean_released_at: got %0d expected 10", r_at[0]); else passes++;
    checks++; if (r_cnt[0] != 1) $display("FAIL clean_released_cnt: got %0d expected 1", r_cnt[0]); else passes++;
    checks++; if (o_cnt[0] != 9) $display("FAIL clean_out_fall: got %0d high cycles expected 9", o_cnt[0]); else passes++;
    settle();
  endtask

  task automatic test_bounce();
    clear_mon();
    for (int k = 0; k < 5; k++) begin
      din[1] = 1'b1; steps(3);
      din[1] = 1'b0; steps(1);
    end
    din[1] = 1'b1;
    steps(25);
    checks++; if (p_cnt[1] != 1) $display("FAIL bounce_pressed_cnt: got %0d expected 1", p_cnt[1]); else passes++;
    checks++; if (p_at[1] != 30) $display("FAIL bounce_pressed_at: got %0d expected 30", p_at[1]); else passes++;
    checks++; if (r_cnt[1] != 0) $display("FAIL bounce_released_cnt: got %0d expected 0", r_cnt[1]); else passes++;
    settle();
  endtask

  task automatic test_glitch();
    clear_mon();
    din[2] = 1'b1; steps(7);
    din[2] = 1'b0; steps(23);
    checks++; if (o_cnt[2] != 0) $display("FAIL glitch_out: got %0d high cycles expected 0", o_cnt[2]); else passes++;
    checks++; if (p_cnt[2] != 0) $display("FAIL glitch_pressed: got %0d expected 0", p_cnt[2]); else passes++;
    checks++; if (r_cnt[2] != 0) $display("FAIL glitch_released: got %0d expected 0", r_cnt[2]); else passes++;
  endtask

  task automatic test_long_press();
    clear_mon();
    din[2] = 1'b1; steps(40);
    din[2] = 1'b0; steps(30);
    checks++; if (p_at[2] != 10) $display("FAIL long_pressed_at: got %0d expected 10", p_at[2]); else passes++;
    checks++; if (l_cnt[2] != 1) $display("FAIL long_cnt: got %0d expected 1", l_cnt[2]); else passes++;
    checks++; if (l_at[2] != 30) $display("FAIL long_at: got %0d expected 30", l_at[2]); else passes++;
    checks++; if (r_at[2] != 50) $display("FAIL long_released_at: got %0d expected 50", r_at[2]); else passes++;
    settle();
    clear_mon();
    din[2] = 1'b1; steps(15);
    din[2] = 1'b0; steps(30);
    checks++; if (p_cnt[2] != 1) $display("FAIL short_pressed_cnt: got %0d expected 1", p_cnt[2]); else passes++;
    checks++; if (r_at[2] != 25) $display("FAIL short_released_at: got %0d expected 25", r_at[2]); else passes++;
    checks++; if (l_cnt[2] != 0) $display("FAIL short_long_cnt: got %0d expected 0", l_cnt[2]); else passes++;
    settle();
  endtask

  task automatic test_simultaneous_reset();
    clear_mon();
    din = 4'hF;
    steps(9);
    checks++; if (pressed !== 4'h0) $display("FAIL sim_pressed_c9: got %h expected 0", pressed); else passes++;
    steps(1);
    checks++; if (pressed !== 4'hF) $display("FAIL sim_pressed_c10: got %h expected f", pressed); else passes++;
    steps(4);
    rst = 1'b1;
    steps(1);
    checks++; if (dout !== 4'h0) $display("FAIL sim_rst_out: got %h expected 0", dout); else passes++;
    checks++; if ({pressed, released, long_press} !== 12'h0) $display("FAIL sim_rst_pulses: got %h expected 0", {pressed, released, long_press}); else passes++;
    steps(1);
    rst = 1'b0;
    steps(9);
    checks++; if (pressed !== 4'h0) $display("FAIL sim_repress_c25: got %h expected 0", pressed); else passes++;
    steps(1);
    checks++; if (pressed !== 4'hF) $display("FAIL sim_repress_c26: got %h expected f", pressed); else passes++;
    checks++; if (dout !== 4'hF) $display("FAIL sim_repress_out: got %h expected f", dout); else passes++;
    steps(14);
    checks++; if ((r_cnt[0] + r_cnt[1] + r_cnt[2] + r_cnt[3]) != 0)
      $display("FAIL sim_no_released: got %0d expected 0", r_cnt[0] + r_cnt[1] + r_cnt[2] + r_cnt[3]); else passes++;
    checks++; if ((l_cnt[0] + l_cnt[1] + l_cnt[2] + l_cnt[3]) != 0)
      $display("FAIL sim_no_long: got %0d expected 0", l_cnt[0] + l_cnt[1] + l_cnt[2] + l_cnt[3]); else passes++;
    checks++; if (p_cnt[1] != 2) $display("FAIL sim_pressed_cnt: got %0d expected 2", p_cnt[1]); else passes++;
    settle();
  endtask

  initial begin
    rst = 1'b1;
    din = 4'h0;
    clear_mon();
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_long_press();
    test_simultaneous_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
